// File: rtl/async_fifo_write_arbiter.sv
// Round-robin, burst-granting arbiter in front of an async FIFO write port.
// Optional per-requester statistics are enabled with `define ASYNC_FIFO_ARB_STATS_EN.
module async_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          write_clk,
  input  logic                          write_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          p_write_full,
  output logic                          p_write_en,
  output logic [DATA_WIDTH-1:0]         p_write_data,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         beat_count,
  output logic [15:0]                   stall_count,
  input  logic                          stats_clr
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [ID_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [ID_W-1:0]   grant_id_r, grant_id_s;
  logic              grant_valid_r, grant_valid_s;
  logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_s;
  logic [ID_W-1:0]   pick_s, sel_s;
  logic              any_s;
  logic              accept_s;
  logic              cur_valid_s, cur_last_s;
  logic [DATA_WIDTH-1:0] cur_data_s;

  assign cur_valid_s = req_valid[grant_id_r];
  assign cur_last_s  = req_last[grant_id_r];
  assign cur_data_s  = req_data[grant_id_r*DATA_WIDTH +: DATA_WIDTH];
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

  // Round-robin search: walking backwards leaves the first hit from rr_ptr in pick_s.
  always_comb begin
    pick_s = rr_ptr_r;
    any_s  = 1'b0;
    sel_s  = rr_ptr_r;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sel_s = ID_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      if (req_valid[sel_s]) begin
        pick_s = sel_s;
        any_s  = 1'b1;
      end else begin
        any_s  = any_s;
      end
    end
  end

  // Next-state and write-port outputs; full freezes everything in BURST.
  always_comb begin
    state_s       = state_r;
    rr_ptr_s      = rr_ptr_r;
    grant_id_s    = grant_id_r;
    grant_valid_s = grant_valid_r;
    beat_cnt_s    = beat_cnt_r;
    accept_s      = 1'b0;
    p_write_en    = 1'b0;
    req_ready     = '0;
    p_write_data  = '0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          grant_id_s    = pick_s;
          grant_valid_s = 1'b1;
          state_s       = BURST;
        end else begin
          grant_valid_s = 1'b0;
        end
      end
      BURST: begin
        p_write_data = cur_data_s;
        if (cur_valid_s && !p_write_full) begin
          accept_s              = 1'b1;
          p_write_en            = 1'b1;
          req_ready[grant_id_r] = 1'b1;
          if (cur_last_s || (beat_cnt_r == CNT_W'(MAX_BURST - 1))) begin
            state_s       = IDLE;
            grant_valid_s = 1'b0;
            beat_cnt_s    = '0;
            rr_ptr_s      = ID_W'((int'(grant_id_r) + 1) % NUM_REQ);
          end else begin
            beat_cnt_s    = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      default: begin
        state_s       = IDLE;
        grant_valid_s = 1'b0;
        beat_cnt_s    = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      grant_id_r    <= '0;
      grant_valid_r <= 1'b0;
      beat_cnt_r    <= '0;
    end else begin
      state_r       <= state_s;
      rr_ptr_r      <= rr_ptr_s;
      grant_id_r    <= grant_id_s;
      grant_valid_r <= grant_valid_s;
      beat_cnt_r    <= beat_cnt_s;
    end
  end

`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [15:0] stat_beats_r [NUM_REQ];
  logic [15:0] stat_stall_r;
  logic        stall_s;

  assign stall_s     = (state_r == BURST) && cur_valid_s && p_write_full;
  assign stall_count = stat_stall_r;

  // Saturating counters; clear wins over increment.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_beats_r[i] <= 16'd0;
      stat_stall_r <= 16'd0;
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) stat_beats_r[i] <= 16'd0;
      stat_stall_r <= 16'd0;
    end else begin
      if (accept_s && (stat_beats_r[grant_id_r] != 16'hFFFF)) begin
        stat_beats_r[grant_id_r] <= stat_beats_r[grant_id_r] + 16'd1;
      end
      if (stall_s && (stat_stall_r != 16'hFFFF)) begin
        stat_stall_r <= stat_stall_r + 16'd1;
      end
    end
  end

  // Flatten per-requester counters onto the output bus.
  always_comb begin
    beat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) beat_count[i*16 +: 16] = stat_beats_r[i];
  end
`endif

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Directed self-checking bench for async_fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_async_fifo_write_arbiter;

  logic        write_clk = 1'b0;
  logic        write_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        p_write_full;
  logic        p_write_en;
  logic [7:0]  p_write_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [63:0] beat_count;
  logic [15:0] stall_count;
  logic        stats_clr;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] wr_q[$];

  always #5 write_clk = ~write_clk;

  async_fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .write_clk(write_clk), .write_rst_n(write_rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .p_write_full(p_write_full),
    .p_write_en(p_write_en), .p_write_data(p_write_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
`ifdef ASYNC_FIFO_ARB_STATS_EN
    , .beat_count(beat_count), .stall_count(stall_count), .stats_clr(stats_clr)
`endif
  );

  // FIFO-side scoreboard capture.
  always @(posedge write_clk) if (p_write_en) wr_q.push_back(p_write_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic tick();
    @(posedge write_clk);
    #2;
  endtask

  // Check one cycle's outputs (data only when a beat is expected), then advance.
  task automatic exp_cyc(input string tag, input logic gv, input logic [1:0] gid,
                         input logic en, input logic [3:0] rdy, input logic [7:0] data);
    #1;
    chk({tag, ".gv"},  32'(grant_valid), 32'(gv));
    chk({tag, ".gid"}, 32'(grant_id), 32'(gid));
    chk({tag, ".en"},  32'(p_write_en), 32'(en));
    chk({tag, ".rdy"}, 32'(req_ready), 32'(rdy));
    if (en) chk({tag, ".data"}, 32'(p_write_data), 32'(data));
    chk({tag, ".en_while_full"}, 32'(p_write_en && p_write_full), 32'd0);
    chk({tag, ".onehot"}, 32'($onehot0(req_ready)), 32'd1);
    tick();
  endtask

  initial begin
    int base;
    write_rst_n = 1'b0; req_valid = 4'b0; req_data = 32'h0; req_last = 4'b0; p_write_full = 1'b0;
`ifdef ASYNC_FIFO_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    @(posedge write_clk); tick();
    chk("rst.gv", 32'(grant_valid), 32'd0);
    chk("rst.gid", 32'(grant_id), 32'd0);
    chk("rst.en", 32'(p_write_en), 32'd0);
    chk("rst.rdy", 32'(req_ready), 32'd0);
    chk("rst.data", 32'(p_write_data), 32'd0);
    write_rst_n = 1'b1;
    tick();

    // Single requester, 3-beat burst.
    req_valid = 4'b0001; set_data(0, 8'hA0);
    exp_cyc("t1.arb", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
    exp_cyc("t1.b0", 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0);
    set_data(0, 8'hA1);
    exp_cyc("t1.b1", 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA1);
    set_data(0, 8'hA2); req_last = 4'b0001;
    exp_cyc("t1.b2", 1'b1, 2'd0, 1'b1, 4'b0001, 8'hA2);
    req_valid = 4'b0; req_last = 4'b0;
    exp_cyc("t1.end", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);

    // Reset to rr_ptr=0, then all four requesters with 1-beat bursts.
    write_rst_n = 1'b0; tick(); write_rst_n = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      exp_cyc("t2.idle", 1'b0, (k == 0) ? 2'd0 : 2'((k - 1) % 4), 1'b0, 4'b0000, 8'h00);
      exp_cyc("t2.beat", 1'b1, 2'(k % 4), 1'b1, 4'(4'b0001 << (k % 4)), 8'(8'h10 + k % 4));
    end
    req_valid = 4'b0; req_last = 4'b0;
    exp_cyc("t2.end", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);

    // Requesters 1 and 2 streaming without last: MAX_BURST forces alternation.
    req_valid = 4'b0110; set_data(1, 8'h11); set_data(2, 8'h22);
    for (int b = 0; b < 4; b++) begin
      exp_cyc("t3.idle", 1'b0, (b == 0) ? 2'd0 : ((b % 2 == 1) ? 2'd1 : 2'd2), 1'b0, 4'b0000, 8'h00);
      for (int j = 0; j < 4; j++)
        exp_cyc("t3.beat", 1'b1, (b % 2 == 0) ? 2'd1 : 2'd2, 1'b1,
                (b % 2 == 0) ? 4'b0010 : 4'b0100, (b % 2 == 0) ? 8'h11 : 8'h22);
    end
    req_valid = 4'b0;
    exp_cyc("t3.end", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);

    // Full for 5 cycles mid-burst on requester 3.
    base = wr_q.size();
    req_valid = 4'b1000; set_data(3, 8'h30);
    exp_cyc("t4.arb", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);
    exp_cyc("t4.b0", 1'b1, 2'd3, 1'b1, 4'b1000, 8'h30);
    set_data(3, 8'h31);
    exp_cyc("t4.b1", 1'b1, 2'd3, 1'b1, 4'b1000, 8'h31);
    set_data(3, 8'h32); p_write_full = 1'b1;
    for (int s = 0; s < 5; s++) exp_cyc("t4.full", 1'b1, 2'd3, 1'b0, 4'b0000, 8'h00);
    p_write_full = 1'b0;
    exp_cyc("t4.b2", 1'b1, 2'd3, 1'b1, 4'b1000, 8'h32);
    set_data(3, 8'h33);
    exp_cyc("t4.b3", 1'b1, 2'd3, 1'b1, 4'b1000, 8'h33);
    req_valid = 4'b0;
    exp_cyc("t4.end", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
    chk("t4.sb_count", 32'(wr_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < wr_q.size()) chk("t4.sb_data", 32'(wr_q[base + i]), 32'(8'h30 + i));

    // Asynchronous reset during beat 2.
    req_valid = 4'b0001; set_data(0, 8'h40);
    exp_cyc("t5.arb", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
    exp_cyc("t5.b0", 1'b1, 2'd0, 1'b1, 4'b0001, 8'h40);
    set_data(0, 8'h41);
    #1;
    chk("t5.b1_en", 32'(p_write_en), 32'd1);
    write_rst_n = 1'b0;
    #1;
    chk("t5.rst_en", 32'(p_write_en), 32'd0);
    chk("t5.rst_rdy", 32'(req_ready), 32'd0);
    chk("t5.rst_gv", 32'(grant_valid), 32'd0);
    chk("t5.rst_gid", 32'(grant_id), 32'd0);
    chk("t5.rst_data", 32'(p_write_data), 32'd0);
    tick();
    req_valid = 4'b1000; req_last = 4'b1000; set_data(3, 8'h50);
    write_rst_n = 1'b1;
    exp_cyc("t5.arb3", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
    exp_cyc("t5.g3", 1'b1, 2'd3, 1'b1, 4'b1000, 8'h50);
    req_valid = 4'b1001; req_last = 4'b1001; set_data(0, 8'h60);
    exp_cyc("t5.arb0", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
    exp_cyc("t5.g0", 1'b1, 2'd0, 1'b1, 4'b0001, 8'h60);
    req_valid = 4'b0; req_last = 4'b0;
    exp_cyc("t5.end", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);

`ifdef ASYNC_FIFO_ARB_STATS_EN
    begin
      int acc;
      int stalls;
      acc = 0; stalls = 0;
      stats_clr = 1'b1; tick(); stats_clr = 1'b0;
      req_valid = 4'b0010; set_data(1, 8'h77);
      for (int cyc = 0; cyc < 2000 && acc < 300; cyc++) begin
        p_write_full = (stalls < 7 && acc >= 50 && grant_valid) ? 1'b1 : 1'b0;
        if (p_write_full) stalls++;
        #1;
        if (p_write_en) acc++;
        tick();
      end
      req_valid = 4'b0; p_write_full = 1'b0;
      chk("st.beats_seen", 32'(acc), 32'd300);
      chk("st.beat1", 32'(beat_count[31:16]), 32'd300);
      chk("st.beat0", 32'(beat_count[15:0]), 32'd0);
      chk("st.stall", 32'(stall_count), 32'd7);
      stats_clr = 1'b1; tick(); stats_clr = 1'b0;
      #1;
      chk("st.clr_beats", 32'(beat_count != 64'd0), 32'd0);
      chk("st.clr_stall", 32'(stall_count), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
